seg7_scan: RTL
==============

Name: seg7_scan

Overview:
- Multiplexed 8-digit seven-segment display driver on the board clock domain.
- Consumer side of the board clocking scheme: generates its own digit-scan rate from clk_board and drives the board's common-anode display from a 32-bit hex value supplied by the CPU/debug logic.
- Provides per-frame coherent capture of display data, a ghosting blanking gap, and optional leading-zero blanking.

Parameters:
SCAN_DIV, 50000, clk_board cycles per digit slot (≥ 4).
BLANK_CYC, 16, cycles at the start of each slot with all anodes off (1 ≤ BLANK_CYC < SCAN_DIV).
NUM_DIGITS, 8, digits scanned (1..8). Digit i shows data[4i+3:4i].
LZB, 0, 1 = leading-zero blanking enabled.

Ports:
clk_board  in   1   board clock. Single clock domain.
rst_n      in   1   asynchronous, active-low reset.
data       in   32  hex value to display.
digit_en   in   8   per-digit enable. 0 = digit dark.
dp_in      in   8   per-digit decimal point. 1 = lit.
an         out  8   anode selects, active-low, one-hot-low when on.
seg        out  7   cathodes {g,f,e,d,c,b,a}, active-low.
dp         out  1   decimal-point cathode, active-low.
frame_sync out  1   one-cycle pulse when new shadow data is captured.

Behaviour:
- Reset (async assert, sync release): prescaler=0, idx=0, shadow data/digit_en/dp=0, an=8'hFF, seg=7'h7F, dp=1, frame_sync=0.
- Prescaler cnt counts 0..SCAN_DIV-1. tick = (cnt==SCAN_DIV-1). cnt wraps to 0 on tick.
- idx counts 0..NUM_DIGITS-1 and advances on tick. On tick with idx==NUM_DIGITS-1, idx wraps to 0.
- Frame start = tick && idx==NUM_DIGITS-1. On that cycle, shadow_data, shadow_en, and shadow_dp load from the inputs, and frame_sync is registered high for exactly one cycle. Input changes at any other time have no visible effect until the next frame.
- Display phase, evaluated from the current cnt/idx:
  - If cnt < BLANK_CYC: blank, an=FF, seg=7F, dp=1.
  - Otherwise, if digit idx is suppressed: an=FF.
  - Otherwise: an = ~(1<<idx), seg = decode(nibble idx), dp = ~shadow_dp[idx].
- Suppressed means any of:
  - shadow_en[idx]==0;
  - LZB=1 and idx>0 and shadow nibbles idx..NUM_DIGITS-1 are all zero. Digit 0 is never LZB-suppressed.
- an, seg, and dp are registered: they reflect cnt/idx of the previous cycle (latency 1). frame_sync is also registered.
- Decode, active-low gfedcba:
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000
  - 8=0000000, 9=0010000, A=0001000, b=0000011, C=1000110, d=0100001, E=0000110, F=0001110.
- Never more than one anode low in any cycle. Slot period = SCAN_DIV cycles. Frame period = NUM_DIGITS*SCAN_DIV cycles.
- The first frame after reset is fully dark because shadow_en resets to 0. Inputs first appear after the first frame_sync.
- Reset asserted mid-slot: outputs go to reset values immediately (async), and the scan restarts at idx 0, cnt 0.
- Widths: cnt is $clog2(SCAN_DIV) bits, idx is 3 bits. Unused digits (idx ≥ NUM_DIGITS) are never selected.

Test Plan (bench uses SCAN_DIV=8, BLANK_CYC=2, NUM_DIGITS=8 unless stated):
- Reset check:
  - Stimulus: hold rst_n=0 for 5 cycles, then release.
  - Required: an=FF, seg=7F, dp=1 throughout. First frame_sync exactly 64 cycles after release. All anodes FF for those 64 cycles.
- Full scan:
  - Stimulus: data=32'h89ABCDEF, digit_en=FF, dp_in=8'h01.
  - Required: after frame_sync, digit 0 lit with an=FE, seg=0001110 (F), dp=0 for 6 cycles, preceded by 2 blank cycles. Digit 7 shows an=7F, seg=0000000 (8), dp=1. Sequence wraps to digit 0 every 64 cycles.
- Frame coherence:
  - Stimulus: change data from 32'h11111111 to 32'h22222222 while idx=3.
  - Required: digits 3..7 of the current frame still show 1 (1111001). Every digit shows 2 (0100100) only after the next frame_sync.
- Leading-zero blanking:
  - Stimulus: LZB=1, data=32'h00000A05, digit_en=FF.
  - Required: digits 0..2 show 5/0/A. Digits 3..7 have an=FF in their slots.
  - Stimulus: data=0.
  - Required: only digit 0 is lit, showing 0 (1000000).
- Digit enable mask:
  - Stimulus: digit_en=8'b00000100, data=32'h76543210.
  - Required: only slot 2 drives an=FB with seg=0100100. All other slots an=FF. The one-low-anode invariant holds every cycle.
- Reset mid-operation:
  - Stimulus: assert rst_n=0 at idx=5, cnt=4, asynchronously.
  - Required: an=FF in the same cycle. After release, scan restarts at idx 0, and the next frame_sync follows 64 cycles later.

Source files
------------

// File: rtl/seg7_scan.sv
// Multiplexed common-anode seven-segment driver: scans NUM_DIGITS digits from a
// per-frame shadow copy of the hex data, with a blanking gap at the start of each slot.
module seg7_scan #(
    parameter int SCAN_DIV   = 50000,
    parameter int BLANK_CYC  = 16,
    parameter int NUM_DIGITS = 8,
    parameter bit LZB        = 1'b0
) (
    input  logic        clk_board,
    input  logic        rst_n,
    input  logic [31:0] data,
    input  logic [7:0]  digit_en,
    input  logic [7:0]  dp_in,
    output logic [7:0]  an,
    output logic [6:0]  seg,
    output logic        dp,
    output logic        frame_sync
);

    localparam int CW = $clog2(SCAN_DIV);
    localparam logic [63:0] MASK64 = (64'd1 << (4 * NUM_DIGITS)) - 64'd1;
    localparam logic [31:0] DMASK  = MASK64[31:0];

    logic [CW-1:0] cnt;
    logic [2:0]    idx;
    logic [31:0]   shadow_data;
    logic [7:0]    shadow_en;
    logic [7:0]    shadow_dp;

    logic          tick;
    logic          frame_start;
    logic          blank;
    logic          suppressed;
    logic [3:0]    nibble;
    logic [31:0]   upper;
    logic [7:0]    an_d;
    logic [6:0]    seg_d;
    logic          dp_d;

    function automatic logic [6:0] decode(input logic [3:0] v);
        case (v)
            4'h0: decode = 7'b1000000;
            4'h1: decode = 7'b1111001;
            4'h2: decode = 7'b0100100;
            4'h3: decode = 7'b0110000;
            4'h4: decode = 7'b0011001;
            4'h5: decode = 7'b0010010;
            4'h6: decode = 7'b0000010;
            4'h7: decode = 7'b1111000;
            4'h8: decode = 7'b0000000;
            4'h9: decode = 7'b0010000;
            4'hA: decode = 7'b0001000;
            4'hB: decode = 7'b0000011;
            4'hC: decode = 7'b1000110;
            4'hD: decode = 7'b0100001;
            4'hE: decode = 7'b0000110;
            default: decode = 7'b0001110;
        endcase
    endfunction

    assign tick        = (cnt == CW'(SCAN_DIV - 1));
    assign frame_start = tick && (idx == 3'(NUM_DIGITS - 1));
    assign blank       = (cnt < CW'(BLANK_CYC));
    assign nibble      = shadow_data[{idx, 2'b00} +: 4];
    // Nibbles idx and above, with digits beyond NUM_DIGITS masked off.
    assign upper       = (shadow_data & DMASK) >> {idx, 2'b00};
    assign suppressed  = !shadow_en[idx] || (LZB && (idx != 3'd0) && (upper == 32'd0));

    always_comb begin
        an_d  = 8'hFF;
        seg_d = 7'h7F;
        dp_d  = 1'b1;
        if (!blank && !suppressed) begin
            an_d  = ~(8'd1 << idx);
            seg_d = decode(nibble);
            dp_d  = ~shadow_dp[idx];
        end
    end

    always_ff @(posedge clk_board or negedge rst_n) begin
        if (!rst_n) begin
            cnt         <= '0;
            idx         <= '0;
            shadow_data <= '0;
            shadow_en   <= '0;
            shadow_dp   <= '0;
            an          <= 8'hFF;
            seg         <= 7'h7F;
            dp          <= 1'b1;
            frame_sync  <= 1'b0;
        end else begin
            an         <= an_d;
            seg        <= seg_d;
            dp         <= dp_d;
            frame_sync <= frame_start;
            if (tick) begin
                cnt <= '0;
                idx <= (idx == 3'(NUM_DIGITS - 1)) ? 3'd0 : idx + 3'd1;
            end else begin
                cnt <= cnt + CW'(1);
            end
            if (frame_start) begin
                shadow_data <= data;
                shadow_en   <= digit_en;
                shadow_dp   <= dp_in;
            end
        end
    end

endmodule
